// File: rtl/seq_signed_divider.sv
// Iterative signed divider: 2W-bit dividend / W-bit divisor, restoring radix-2 on magnitudes plus sign fix-up.
// Optional status outputs div_by_zero / div_overflow are built when DIV_STATUS_FLAGS_EN is defined.
module seq_signed_divider #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*W-1:0]  dividend,
  input  logic [W-1:0]    divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  quotient,
  output logic [2*W-1:0]  remainder
`ifdef DIV_STATUS_FLAGS_EN
  ,
  output logic            div_by_zero,
  output logic            div_overflow
`endif
);
  localparam int DW = 2 * W;
  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [DW-1:0]   dvd_q, dvd_d;   // dividend magnitude, quotient bits shift in at the LSB
  logic [W-1:0]    dsr_q, dsr_d;
  logic [W-1:0]    pr_q, pr_d;     // partial remainder never reaches |divisor| <= 2^(W-1)
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic            dbz_q, dbz_d, ovf_q, ovf_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   quotient_q, quotient_d, remainder_q, remainder_d;
  logic [W:0]      pr_shift;
  logic [DW-1:0]   rmag;
`ifdef DIV_STATUS_FLAGS_EN
  logic            dbz_flag_q, dbz_flag_d, ovf_flag_q, ovf_flag_d;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    pr_d        = pr_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    pr_shift    = {pr_q, dvd_q[DW-1]};
    rmag        = {{(DW-W){1'b0}}, pr_q};
`ifdef DIV_STATUS_FLAGS_EN
    dbz_flag_d  = dbz_flag_q;
    ovf_flag_d  = ovf_flag_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = dividend;
        b_d     = divisor;
        state_d = PREP;
      end
      PREP: begin
        // Magnitudes are formed one bit wider so -2^(DW-1) negates correctly.
        dvd_d   = DW'(a_q[DW-1] ? -{a_q[DW-1], a_q} : {a_q[DW-1], a_q});
        dsr_d   = W'(b_q[W-1] ? -{b_q[W-1], b_q} : {b_q[W-1], b_q});
        qneg_d  = a_q[DW-1] ^ b_q[W-1];
        rneg_d  = a_q[DW-1];
        pr_d    = '0;
        cnt_d   = '0;
        dbz_d   = (b_q == '0);
        ovf_d   = (a_q == {1'b1, {(DW-1){1'b0}}}) && (b_q == '1);
        // Special cases skip the iterations; FIX loads their fixed results.
        state_d = (dbz_d || ovf_d) ? FIX : DIV;
      end
      DIV: begin
        if (pr_shift >= {1'b0, dsr_q}) begin
          pr_d  = W'(pr_shift - {1'b0, dsr_q});
          dvd_d = {dvd_q[DW-2:0], 1'b1};
        end else begin
          pr_d  = pr_shift[W-1:0];
          dvd_d = {dvd_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) state_d = FIX;
      end
      FIX: begin
        if (dbz_q) begin
          quotient_d  = '1;
          remainder_d = a_q;
        end else if (ovf_q) begin
          quotient_d  = a_q;
          remainder_d = '0;
        end else begin
          quotient_d  = qneg_q ? -dvd_q : dvd_q;
          remainder_d = rneg_q ? -rmag : rmag;
        end
`ifdef DIV_STATUS_FLAGS_EN
        dbz_flag_d  = dbz_q;
        ovf_flag_d  = ovf_q;
`endif
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
`ifdef DIV_STATUS_FLAGS_EN
        dbz_flag_d  = 1'b0;
        ovf_flag_d  = 1'b0;
`endif
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      pr_q        <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_STATUS_FLAGS_EN
      dbz_flag_q  <= 1'b0;
      ovf_flag_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      pr_q        <= pr_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIV_STATUS_FLAGS_EN
      dbz_flag_q  <= dbz_flag_d;
      ovf_flag_q  <= ovf_flag_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef DIV_STATUS_FLAGS_EN
  assign div_by_zero  = dbz_flag_q;
  assign div_overflow = ovf_flag_q;
`endif
endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed test-plan cases, random ops vs a
// plain-arithmetic reference, backpressure and mid-operation reset.
module tb_seq_signed_divider;
  localparam int W  = 8;
  localparam int DW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
`ifdef DIV_STATUS_FLAGS_EN
  logic          div_by_zero, div_overflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_signed_divider #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder)
`ifdef DIV_STATUS_FLAGS_EN
    , .div_by_zero(div_by_zero), .div_overflow(div_overflow)
`endif
  );

  // Reference: truncating signed division on integers, plus the two special cases.
  function automatic void model(input logic [DW-1:0] a, input logic [W-1:0] b,
                                output logic [DW-1:0] q, output logic [DW-1:0] r,
                                output int lat, output logic fz, output logic fo);
    longint al, bl;
    al = longint'($signed(a));
    bl = longint'($signed(b));
    fz = 1'b0; fo = 1'b0;
    if (bl == 0) begin
      q = '1; r = a; lat = 2; fz = 1'b1;
    end else if (al == -(longint'(1) << (DW - 1)) && bl == -1) begin
      q = a; r = '0; lat = 2; fo = 1'b1;
    end else begin
      q = DW'(al / bl); r = DW'(al % bl); lat = 2 * W + 2;
    end
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin @(negedge clk); n++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL accept_wait: in_ready=%b required=1", in_ready);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [W-1:0] b,
                        output logic [DW-1:0] q, output logic [DW-1:0] r,
                        output int lat, output logic fz, output logic fo);
    wait_ready();
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid(lat);
    q = quotient; r = remainder;
`ifdef DIV_STATUS_FLAGS_EN
    fz = div_by_zero; fo = div_overflow;
`else
    fz = 1'b0; fo = 1'b0;
`endif
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0) begin
      bad++; $display("FAIL reset_state: rdy=%b vld=%b q=%h r=%h required 1/0/0/0",
                      in_ready, out_valid, quotient, remainder);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [DW-1:0] ta[8], tq[8], tr[8];
    logic [W-1:0]  tb[8];
    int            tl[8];
    logic [DW-1:0] q, r;
    int            lat;
    logic          fz, fo;
    ta = '{16'd1000, -16'sd1000, 16'd1000, -16'sd1000, 16'd1234, 16'h8000, 16'h8000, 16'd255};
    tb = '{8'd7, 8'd7, -8'sd7, -8'sd7, 8'd0, 8'hFF, 8'd1, 8'h80};
    tq = '{16'd142, -16'sd142, -16'sd142, 16'd142, 16'hFFFF, 16'h8000, 16'h8000, -16'sd1};
    tr = '{16'd6, -16'sd6, 16'd6, -16'sd6, 16'd1234, 16'd0, 16'd0, 16'd127};
    tl = '{18, 18, 18, 18, 2, 2, 18, 18};
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], q, r, lat, fz, fo);
      total++;
      if (q !== tq[i] || r !== tr[i] || lat != tl[i]) begin
        bad++; $display("FAIL directed_%0d: q=%h r=%h lat=%0d required q=%h r=%h lat=%0d",
                        i, q, r, lat, tq[i], tr[i], tl[i]);
      end
`ifdef DIV_STATUS_FLAGS_EN
      total++;
      if (fz !== (i == 4) || fo !== (i == 5)) begin
        bad++; $display("FAIL flags_%0d: dbz=%b ovf=%b required %b/%b", i, fz, fo, i == 4, i == 5);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] a, q, r, eq, er;
    logic [W-1:0]  b;
    int            lat, elat;
    logic          fz, fo, efz, efo;
    for (int i = 0; i < 40; i++) begin
      a = DW'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 9) == 0) b = '0;
      if ($urandom_range(0, 19) == 0) begin a = 16'h8000; b = '1; end
      model(a, b, eq, er, elat, efz, efo);
      run_op(a, b, q, r, lat, fz, fo);
      total++;
      if (q !== eq || r !== er || lat != elat) begin
        bad++; $display("FAIL random %h/%h: q=%h r=%h lat=%0d required q=%h r=%h lat=%0d",
                        a, b, q, r, lat, eq, er, elat);
      end
`ifdef DIV_STATUS_FLAGS_EN
      total++;
      if (fz !== efz || fo !== efo) begin
        bad++; $display("FAIL random_flags: dbz=%b ovf=%b required %b/%b", fz, fo, efz, efo);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] q, r;
    int            lat, errs;
    logic          fz, fo;
    wait_ready();
    dividend = 16'd1000; divisor = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    dividend = 16'd5; divisor = 8'd1; in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL busy_ready: in_ready=%b required=0", in_ready);
    end
    @(negedge clk) in_valid = 1'b0;
    #1 wait_valid(lat);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) in_valid = 1'b1;
      if (out_valid !== 1'b1 || quotient !== 16'd142 || remainder !== 16'd6 || in_ready !== 1'b0)
        errs++;
    end
    in_valid = 1'b0;
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL hold_stable: %0d unstable cycles, required 0 (q=%h r=%h)",
                      errs, quotient, remainder);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    run_op(16'd100, 8'd10, q, r, lat, fz, fo);
    total++;
    if (q !== 16'd10 || r !== 16'd0 || lat != 18) begin
      bad++; $display("FAIL after_bp: q=%h r=%h lat=%0d required 000a/0000/18", q, r, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] q, r;
    int            lat, stale;
    logic          fz, fo;
    wait_ready();
    dividend = 16'd32767; divisor = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== '0 || remainder !== '0) begin
      bad++; $display("FAIL async_reset: vld=%b rdy=%b q=%h r=%h required 0/1/0/0",
                      out_valid, in_ready, quotient, remainder);
    end
    @(negedge clk) rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++; $display("FAIL stale_result: out_valid seen %0d cycles, required 0", stale);
    end
    run_op(16'd32767, 8'd3, q, r, lat, fz, fo);
    total++;
    if (q !== 16'd10922 || r !== 16'd1 || lat != 18) begin
      bad++; $display("FAIL after_reset: q=%0d r=%0d lat=%0d required 10922/1/18", q, r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
